// File: rtl/bram_stream_reader_pkg.sv
// bram_stream_reader_pkg: shared FSM encoding and output FIFO sizing
package bram_stream_reader_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
  localparam int FIFO_DEPTH = 4;
  localparam int FIFO_AW = $clog2(FIFO_DEPTH);
endpackage

// File: rtl/bram_stream_reader_stream_fifo.sv
// stream_fifo: small synchronous FIFO holding data plus last marker
module stream_fifo
  import bram_stream_reader_pkg::*;
#(
  parameter int W = 37
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             push,
  input  logic [W-1:0]     din,
  input  logic             pop,
  output logic [W-1:0]     dout,
  output logic [FIFO_AW:0] occ,
  output logic             empty
);
  logic [W-1:0] mem [FIFO_DEPTH];
  logic [FIFO_AW-1:0] wr, rd;
  assign dout = mem[rd];
  assign empty = occ == '0;
  // pointers and occupancy; push and pop may coincide even when full
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      wr <= '0;
      rd <= '0;
      occ <= '0;
    end else begin
      wr <= push ? wr + 1'b1 : wr;
      rd <= pop ? rd + 1'b1 : rd;
      occ <= occ + (FIFO_AW+1)'(push) - (FIFO_AW+1)'(pop);
    end
  end
  // storage needs no reset; occupancy decides what is visible
  always_ff @(posedge clock) begin
    if (push) mem[wr] <= din;
  end
endmodule

// File: rtl/bram_stream_reader.sv
// bram_stream_reader: turns a (base, length) command into sequential BRAM reads presented as a valid/ready stream
module bram_stream_reader
  import bram_stream_reader_pkg::*;
#(
  parameter int WIDTH = 36,
  parameter int LOG_DEP = 6
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               enable,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [LOG_DEP-1:0] cmd_base,
  input  logic [LOG_DEP:0]   cmd_len,
  output logic [LOG_DEP-1:0] ram_raddr,
  input  logic [WIDTH-1:0]   ram_dout,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   out_data,
  output logic               out_last,
  output logic               busy,
  output logic               done
);
  state_t state, state_n;
  logic [LOG_DEP-1:0] addr, raddr_q;
  logic [LOG_DEP:0] remaining;
  logic issue, issue_d, last_d, pop, empty, final_issue;
  logic [FIFO_AW:0] occ;
  logic [WIDTH:0] fifo_dout;
  assign pop = out_valid & out_ready;
  assign final_issue = issue && remaining == (LOG_DEP+1)'(1);
  assign cmd_ready = state == IDLE;
  assign busy = state != IDLE;
  assign out_valid = !empty;
  assign {out_last, out_data} = fifo_dout;
  assign ram_raddr = issue ? addr : raddr_q;
  // state register
  always_ff @(posedge clock) begin
    state <= !reset_n ? IDLE : state_n;
  end
  // issue only while the FIFO plus the in-flight read leaves room for one more word
  always_comb begin
    issue = state == RUN && enable && (int'(occ) + int'(issue_d) < FIFO_DEPTH + int'(pop));
    state_n = state == IDLE ? (cmd_valid && cmd_len != '0 ? RUN : IDLE)
            : state == RUN  ? (final_issue ? DRAIN : RUN)
            : (pop && out_last ? IDLE : DRAIN);
  end
  // address walk, read-latency pipeline and completion pulse
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      addr <= '0;
      remaining <= '0;
      raddr_q <= '0;
      issue_d <= 1'b0;
      last_d <= 1'b0;
      done <= 1'b0;
    end else begin
      issue_d <= issue;
      last_d <= final_issue;
      done <= (state == IDLE && cmd_valid && cmd_len == '0) || (state == DRAIN && pop && out_last);
      if (state == IDLE && cmd_valid) begin
        addr <= cmd_base;
        remaining <= cmd_len;
      end else if (issue) begin
        addr <= addr + 1'b1;
        remaining <= remaining - 1'b1;
        raddr_q <= addr;
      end
    end
  end
  stream_fifo #(.W(WIDTH + 1)) u_fifo (
    .clock  (clock),
    .reset_n(reset_n),
    .push   (issue_d),
    .din    ({last_d, ram_dout}),
    .pop    (pop),
    .dout   (fifo_dout),
    .occ    (occ),
    .empty  (empty)
  );
endmodule

// File: tb/tb_bram_stream_reader.sv
// tb_bram_stream_reader: directed commands with a scoreboard checking every popped word
module tb_bram_stream_reader;
  logic clock = 1'b0, reset_n, enable, cmd_valid, cmd_ready, out_valid, out_ready, out_last, busy, done;
  logic [5:0] cmd_base, ram_raddr;
  logic [6:0] cmd_len;
  logic [35:0] ram_dout, out_data;
  logic [35:0] ram [64];
  logic [36:0] exp_q [$];
  int checks = 0, errors = 0, max_occ = 0;

  bram_stream_reader #(.WIDTH(36), .LOG_DEP(6)) dut (
    .clock(clock), .reset_n(reset_n), .enable(enable), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_base(cmd_base), .cmd_len(cmd_len), .ram_raddr(ram_raddr), .ram_dout(ram_dout),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
    .busy(busy), .done(done)
  );

  always #5 clock = ~clock;

  initial for (int i = 0; i < 64; i++) ram[i] = 36'(100 + i);
  always @(posedge clock) ram_dout <= ram[ram_raddr];

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", name, got, exp);
    end
  endtask

  always @(negedge clock) begin
    if (reset_n && int'(dut.u_fifo.occ) > max_occ) max_occ = int'(dut.u_fifo.occ);
    if (reset_n && out_valid && out_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_word got data %0d last %0b expected none", out_data, out_last);
      end else begin
        logic [36:0] e;
        e = exp_q.pop_front();
        if ({out_last, out_data} !== e) begin
          errors++;
          $display("FAIL stream_word got data %0d last %0b expected data %0d last %0b", out_data, out_last, e[35:0], e[36]);
        end
      end
    end
  end

  task automatic run(input int base, input int len, input int mode, input int en_at, input int rst_after,
                     input int exp_first, input int exp_done);
    int k, first, pops;
    bit fin, aborted;
    for (int i = 0; i < len; i++) exp_q.push_back({i == len - 1, 36'(100 + (base + i) % 64)});
    cmd_valid = 1'b1;
    cmd_base = base[5:0];
    cmd_len = len[6:0];
    @(posedge clock);
    k = 0; first = 0; pops = 0; fin = 0; aborted = 0;
    while (!fin && k < 400) begin
      #1;
      cmd_valid = 1'b0;
      k++;
      out_ready = mode == 0 ? 1'b1 : ((k - 1) % 4 == 0 || (k - 1) % 4 == 3);
      enable = !(k >= en_at && k < en_at + 5);
      if (rst_after > 0 && pops == rst_after) begin
        reset_n = 1'b0;
        out_ready = 1'b0;
        @(posedge clock);
        #1;
        reset_n = 1'b1;
        out_ready = 1'b1;
        @(negedge clock);
        chk("reset_out_valid", out_valid, 0);
        chk("reset_busy", busy, 0);
        chk("reset_cmd_ready", cmd_ready, 1);
        exp_q.delete();
        fin = 1;
        aborted = 1;
      end else begin
        @(negedge clock);
        if (k == 1 && len > 0) chk("first_raddr", ram_raddr, 64'(base));
        if (out_valid && first == 0) first = k;
        if (out_valid && out_ready) pops++;
        if (done) fin = 1;
        else @(posedge clock);
      end
    end
    enable = 1'b1;
    out_ready = 1'b1;
    if (!fin) begin
      checks++;
      errors++;
      $display("FAIL done_timeout got no done within %0d cycles expected done", k);
    end else if (!aborted) begin
      chk("first_valid_cycle", 64'(first), 64'(exp_first));
      if (exp_done > 0) chk("done_cycle", 64'(k), 64'(exp_done));
      chk("idle_busy", busy, 0);
      chk("idle_cmd_ready", cmd_ready, 1);
      chk("words_left", 64'(exp_q.size()), 0);
      @(posedge clock);
      @(negedge clock);
      chk("done_pulse_width", done, 0);
    end
  endtask

  initial begin
    reset_n = 1'b0; enable = 1'b1; cmd_valid = 1'b0; cmd_base = '0; cmd_len = '0; out_ready = 1'b1;
    repeat (2) @(posedge clock);
    @(negedge clock);
    chk("rst_cmd_ready", cmd_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_last", out_last, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_raddr", ram_raddr, 0);
    reset_n = 1'b1;
    @(negedge clock);
    run(5, 4, 0, 1000, 0, 3, 7);
    run(62, 4, 0, 1000, 0, 3, 7);
    max_occ = 0;
    run(7, 16, 1, 1000, 0, 3, 0);
    chk("max_fifo_occ_le4", 64'(max_occ > 4), 0);
    run(0, 0, 0, 1000, 0, 0, 1);
    run(0, 64, 0, 1000, 0, 3, 67);
    run(30, 8, 0, 4, 0, 3, 16);
    run(20, 10, 0, 1000, 3, 3, 0);
    @(negedge clock);
    run(0, 2, 0, 1000, 0, 3, 5);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
